// File: rtl/instruction_ram_loader_pkg.sv
// Shared loader types: FSM state encoding and frame geometry constants.
// Pure declarations; no timing or backpressure of its own.
package instruction_ram_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        PAYLOAD,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_WIDTH    = 16;

endpackage

// File: rtl/instruction_ram_loader_if.sv
// Byte-stream input and RAM write port of the loader; master is the loader side.
// No timing of its own; byte_ready is the only backpressure signal.
interface instruction_ram_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32
);
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [WORD_WIDTH-1:0] write_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, write_enable, write_address, write_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, write_enable, write_address, write_data
    );
endinterface

// File: rtl/instruction_ram_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a word; word_full pulses the cycle after the last byte.
// No backpressure: shifts only when the FSM reports an accepted payload byte.
module loader_word_assembler
    import instruction_ram_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic [1:0]            byte_idx,
    output logic                  word_full
);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            word      <= '0;
            byte_idx  <= '0;
            word_full <= 1'b0;
        end else begin
            // One-cycle pulse; no shift can follow immediately since the FSM holds off in WRITE.
            word_full <= shift_en && (byte_idx == 2'(BYTES_PER_WORD - 1));
            if (shift_en) begin
                word     <= {word[WORD_WIDTH-9:0], byte_in};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instruction_ram_loader.sv
// Assembles a counted big-endian byte frame into words written from BASE_ADDRESS; write 1 cycle after 4th byte.
// byte_ready is low outside CNT_HI/CNT_LO/PAYLOAD/CHECK; LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module instruction_ram_loader
    import instruction_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int WORD_WIDTH   = 32,
    parameter int BASE_ADDRESS = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    instruction_ram_loader_if.master  bus,
    output logic                      busy,
    output logic                      load_done,
    output logic                      load_error
);

    localparam int          WL_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

    loader_state_t          state;
    logic [7:0]             count_hi;
    logic [WL_WIDTH-1:0]    words_left;
    logic [ADDR_WIDTH-1:0]  address;
    logic [COUNT_WIDTH-1:0] count;
    logic                   transfer;
    logic                   clear_word;
    logic                   shift_en;
    logic [1:0]             byte_idx;
    logic [WORD_WIDTH-1:0]  word;
    logic                   word_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign bus.byte_ready = (state == CNT_HI) || (state == CNT_LO) ||
                            (state == PAYLOAD) || (state == CHECK);
    assign transfer   = bus.byte_valid && bus.byte_ready;
    assign count      = {count_hi, bus.byte_in};
    assign clear_word = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign shift_en   = transfer && (state == PAYLOAD);

    assign bus.write_enable  = word_full;
    assign bus.write_address = address;
    assign bus.write_data    = word;

    loader_word_assembler #(.WORD_WIDTH(WORD_WIDTH)) u_assembler (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear_word),
        .shift_en  (shift_en),
        .byte_in   (bus.byte_in),
        .word      (word),
        .byte_idx  (byte_idx),
        .word_full (word_full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            count_hi   <= '0;
            words_left <= '0;
            address    <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
`ifdef LOADER_CHECKSUM_EN
            if (clear_word)
                csum <= '0;
            else if (transfer && (state != CHECK))
                csum <= csum ^ bus.byte_in;
`endif
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= CNT_HI;
                        busy       <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                CNT_HI: begin
                    if (transfer) begin
                        count_hi <= bus.byte_in;
                        state    <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (transfer) begin
                        if (count == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= CHECK;
`else
                            state     <= DONE;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else if (32'(count) > CAPACITY) begin
                            state      <= ERROR;
                            busy       <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            words_left <= WL_WIDTH'(count);
                            address    <= ADDR_WIDTH'(BASE_ADDRESS);
                            state      <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (transfer && (byte_idx == 2'(BYTES_PER_WORD - 1)))
                        state <= WRITE;
                end
                WRITE: begin
                    // The assembler strobes write_enable during this cycle; advance afterwards.
                    address    <= address + 1'b1;
                    words_left <= words_left - 1'b1;
                    if (words_left == WL_WIDTH'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                        state     <= CHECK;
`else
                        state     <= DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
`endif
                    end else begin
                        state <= PAYLOAD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (transfer) begin
                        busy <= 1'b0;
                        if (bus.byte_in == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed bench for instruction_ram_loader: two instances (base 0 and base 1020) share one byte driver.
// Honours LOADER_CHECKSUM_EN by appending the trailing XOR byte to every frame.
module tb_instruction_ram_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic       sel;
    logic       valid;
    logic [7:0] byte_dat;
    logic       busy0, done0, err0;
    logic       busy1, done1, err1;

    always #5 clock = ~clock;

    instruction_ram_loader_if #(.ADDR_WIDTH(10), .WORD_WIDTH(32)) bus0 ();
    instruction_ram_loader_if #(.ADDR_WIDTH(10), .WORD_WIDTH(32)) bus1 ();

    assign bus0.byte_in    = byte_dat;
    assign bus0.byte_valid = valid && !sel;
    assign bus1.byte_in    = byte_dat;
    assign bus1.byte_valid = valid && sel;

    instruction_ram_loader #(.ADDR_WIDTH(10), .WORD_WIDTH(32), .BASE_ADDRESS(0)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start0),
        .bus        (bus0),
        .busy       (busy0),
        .load_done  (done0),
        .load_error (err0)
    );

    instruction_ram_loader #(.ADDR_WIDTH(10), .WORD_WIDTH(32), .BASE_ADDRESS(1020)) u_dut_wrap (
        .clock      (clock),
        .reset      (reset),
        .start      (start1),
        .bus        (bus1),
        .busy       (busy1),
        .load_done  (done1),
        .load_error (err1)
    );

    int          tests  = 0;
    int          failed = 0;
    logic [9:0]  wr_addr0[$];
    logic [31:0] wr_data0[$];
    int          wr_count1 = 0;
    logic [9:0]  first_addr1, last_addr1;
    logic [31:0] last_data1;
    logic [7:0]  csum;
    logic [31:0] words[4];
    logic [15:0] iv;

    always @(negedge clock) begin
        if (bus0.write_enable === 1'b1) begin
            wr_addr0.push_back(bus0.write_address);
            wr_data0.push_back(bus0.write_data);
        end
        if (bus1.write_enable === 1'b1) begin
            if (wr_count1 == 0) first_addr1 = bus1.write_address;
            last_addr1 = bus1.write_address;
            last_data1 = bus1.write_data;
            wr_count1++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        bit   ok;
        if (gap > 0) begin
            valid = 1'b0;
            repeat (gap) begin @(posedge clock); #1; end
        end
        byte_dat = b;
        valid    = 1'b1;
        csum     = csum ^ b;
        ok       = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            rdy = sel ? bus1.byte_ready : bus0.byte_ready;
            @(posedge clock); #1;
            ok = rdy;
        end
        if (!ok) check("byte_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_payload(input int nwords, input int gap);
        logic [31:0] w;
        for (int n = 0; n < nwords; n++) begin
            w = words[n];
            for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
        end
    endtask

    task automatic send_frame(input logic [15:0] cnt, input int nwords, input int gap);
        csum = 8'h00;
        send_byte(cnt[15:8], gap);
        send_byte(cnt[7:0], gap);
        send_payload(nwords, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, gap);
`endif
        valid = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        valid = 1'b0;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        logic b;
        b = which ? busy1 : busy0;
        for (int i = 0; i < 100 && b; i++) begin
            @(posedge clock); #1;
            b = which ? busy1 : busy0;
        end
        if (b) check("idle_timeout", 64'(b), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0; valid = 1'b0; byte_dat = 8'h00;
        csum  = 8'h00;
        repeat (2) @(posedge clock); #1;

        // Reset state
        check("rst_ready", 64'(bus0.byte_ready), 64'd0);
        check("rst_we", 64'(bus0.write_enable), 64'd0);
        check("rst_addr", 64'(bus0.write_address), 64'd0);
        check("rst_data", 64'(bus0.write_data), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_error", 64'(err0), 64'd0);
        check("rst_wrap_addr", 64'(bus1.write_address), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Two-word frame, byte_valid held high
        pulse_start(1'b0);
        check("t1_busy", 64'(busy0), 64'd1);
        check("t1_ready", 64'(bus0.byte_ready), 64'd1);
        csum = 8'h00;
        words[0] = 32'h1122_3344;
        words[1] = 32'hAABB_CCDD;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_payload(2, 0);
        valid = 1'b0;
        check("t1_we_latency", 64'(bus0.write_enable), 64'd1);
        check("t1_we_addr", 64'(bus0.write_address), 64'd1);
        check("t1_we_data", 64'(bus0.write_data), 64'hAABB_CCDD);
        @(posedge clock); #1;
        check("t1_we_one_cycle", 64'(bus0.write_enable), 64'd0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 0);
        valid = 1'b0;
`endif
        check("t1_done", 64'(done0), 64'd1);
        check("t1_busy_off", 64'(busy0), 64'd0);
        check("t1_error", 64'(err0), 64'd0);
        check("t1_nwrites", 64'(wr_addr0.size()), 64'd2);
        check("t1_w0_addr", 64'(wr_addr0[0]), 64'd0);
        check("t1_w0_data", 64'(wr_data0[0]), 64'h1122_3344);
        check("t1_w1_addr", 64'(wr_addr0[1]), 64'd1);

        // Same frame with toggling valid, a 5-cycle gap and a start pulse while busy
        wr_addr0.delete(); wr_data0.delete();
        pulse_start(1'b0);
        csum = 8'h00;
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        pulse_start(1'b0);
        send_byte(8'hAA, 5);
        send_byte(8'hBB, 1);
        send_byte(8'hCC, 1);
        send_byte(8'hDD, 1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 1);
`endif
        valid = 1'b0;
        wait_idle(1'b0);
        check("t2_done", 64'(done0), 64'd1);
        check("t2_nwrites", 64'(wr_addr0.size()), 64'd2);
        check("t2_w0_data", 64'(wr_data0[0]), 64'h1122_3344);
        check("t2_w1_addr", 64'(wr_addr0[1]), 64'd1);
        check("t2_w1_data", 64'(wr_data0[1]), 64'hAABB_CCDD);
        byte_dat = 8'hFF;
        valid    = 1'b1;
        repeat (5) @(posedge clock); #1;
        check("t2_done_ready", 64'(bus0.byte_ready), 64'd0);
        check("t2_done_ignored", 64'(wr_addr0.size()), 64'd2);
        check("t2_done_held", 64'(done0), 64'd1);
        valid = 1'b0;

        // Count 1025 overflows a 1024-word RAM
        wr_addr0.delete(); wr_data0.delete();
        pulse_start(1'b0);
        check("t3_done_cleared", 64'(done0), 64'd0);
        csum = 8'h00;
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        valid = 1'b0;
        @(posedge clock); #1;
        check("t3_error", 64'(err0), 64'd1);
        check("t3_done", 64'(done0), 64'd0);
        check("t3_busy", 64'(busy0), 64'd0);
        check("t3_nwrites", 64'(wr_addr0.size()), 64'd0);

        // Zero-count frame completes without writes
        pulse_start(1'b0);
        check("t3z_error_cleared", 64'(err0), 64'd0);
        send_frame(16'h0000, 0, 0);
        wait_idle(1'b0);
        check("t3z_done", 64'(done0), 64'd1);
        check("t3z_nwrites", 64'(wr_addr0.size()), 64'd0);

        // Reset after 6 payload bytes of a 2-word frame
        pulse_start(1'b0);
        csum = 8'h00;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check("t4_rst_we", 64'(bus0.write_enable), 64'd0);
        check("t4_rst_busy", 64'(busy0), 64'd0);
        check("t4_rst_done", 64'(done0), 64'd0);
        check("t4_rst_error", 64'(err0), 64'd0);
        check("t4_rst_ready", 64'(bus0.byte_ready), 64'd0);
        check("t4_rst_addr", 64'(bus0.write_address), 64'd0);
        check("t4_rst_data", 64'(bus0.write_data), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t4_nwrites", 64'(wr_addr0.size()), 64'd1);
        check("t4_w0_data", 64'(wr_data0[0]), 64'h1122_3344);
        wr_addr0.delete(); wr_data0.delete();
        words[0] = 32'hDEAD_BEEF;
        pulse_start(1'b0);
        send_frame(16'h0001, 1, 0);
        wait_idle(1'b0);
        check("t4_reload_done", 64'(done0), 64'd1);
        check("t4_reload_nwrites", 64'(wr_addr0.size()), 64'd1);
        check("t4_reload_addr", 64'(wr_addr0[0]), 64'd0);
        check("t4_reload_data", 64'(wr_data0[0]), 64'hDEAD_BEEF);

        // Full 1024-word load from base 1020 wraps to 1019
        wr_addr0.delete(); wr_data0.delete();
        sel = 1'b1;
        pulse_start(1'b1);
        csum = 8'h00;
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            iv = 16'(i);
            send_byte(8'hC0, 0);
            send_byte(8'hDE, 0);
            send_byte(iv[15:8], 0);
            send_byte(iv[7:0], 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 0);
`endif
        valid = 1'b0;
        wait_idle(1'b1);
        sel = 1'b0;
        check("t5_nwrites", 64'(wr_count1), 64'd1024);
        check("t5_first_addr", 64'(first_addr1), 64'd1020);
        check("t5_last_addr", 64'(last_addr1), 64'd1019);
        check("t5_last_data", 64'(last_data1), 64'hC0DE_03FF);
        check("t5_done", 64'(done1), 64'd1);
        check("t5_error", 64'(err1), 64'd0);
        check("t5_dut0_quiet", 64'(wr_addr0.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // Trailing byte covers the count bytes too: 00^01^01^02^03^04 = 05
        pulse_start(1'b0);
        csum = 8'h00;
        words[0] = 32'h0102_0304;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_payload(1, 0);
        send_byte(8'h05, 0);
        valid = 1'b0;
        wait_idle(1'b0);
        check("t6_match_done", 64'(done0), 64'd1);
        check("t6_match_error", 64'(err0), 64'd0);
        check("t6_match_nwrites", 64'(wr_addr0.size()), 64'd1);
        wr_addr0.delete(); wr_data0.delete();
        pulse_start(1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_payload(1, 0);
        send_byte(8'h04, 0);
        valid = 1'b0;
        wait_idle(1'b0);
        check("t6_bad_error", 64'(err0), 64'd1);
        check("t6_bad_done", 64'(done0), 64'd0);
        check("t6_bad_kept_write", 64'(wr_data0[0]), 64'h0102_0304);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
